// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ packet streams.
// Ownership lasts a whole packet; an idle gap follows each packet; stalled owners are aborted.
module uart_tx_arb #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 868,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_vld,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_rdy,
  output logic                   tx_vld,
  output logic [7:0]             tx_data,
  input  logic                   tx_rdy,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic                 to_err_q, to_err_d;

  logic [PW-1:0]        idx, sel_idx, owner_nxt;
  logic [NUM_REQ-1:0]   sel_oh;
  logic                 found, own_vld, own_last, abort, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
      to_err_q  <= to_err_d;
    end
  end

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    idx     = '0;
    sel_idx = '0;
    sel_oh  = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_vld[idx]) begin
        found   = 1'b1;
        sel_idx = idx;
      end
    end
    sel_oh[sel_idx] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    to_err_d  = 1'b0;
    own_vld   = req_vld[owner_q];
    own_last  = req_last[owner_q];
    owner_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
    // Abort only with tx_vld low so the transmitter never sees a withdrawn byte.
    abort     = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_MAX) && !tx_vld;
    done      = (tx_vld && tx_rdy && own_last) || abort;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d  = sel_oh;
          owner_d  = sel_idx;
          to_cnt_d = '0;
          state_d  = S_GRANT;
        end
      end
      S_GRANT: begin
        if (own_vld)                to_cnt_d = '0;
        else if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + TW'(1);
        if (done) begin
          rr_ptr_d  = owner_nxt;
          grant_d   = '0;
          to_err_d  = abort;
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // grant_q is zero outside GRANT, which blanks every datapath output.
  always_comb begin
    grant       = grant_q;
    tx_vld      = |(req_vld & grant_q);
    tx_data     = tx_vld ? req_data[{owner_q, 3'b000} +: 8] : 8'h00;
    req_rdy     = grant_q & {NUM_REQ{tx_rdy}};
    busy        = (state_q != S_IDLE);
    timeout_err = to_err_q;
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: NUM_REQ=4, GAP_CYCLES=4, TIMEOUT_CYCLES=16.
module tb_uart_tx_arb;
  localparam int NR  = 4;
  localparam int GAP = 4;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_vld;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_rdy;
  logic            tx_vld;
  logic [7:0]      tx_data;
  logic            tx_rdy;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  logic [11:0] e, o;

  uart_tx_arb #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
    .req_rdy(req_rdy), .tx_vld(tx_vld), .tx_data(tx_data), .tx_rdy(tx_rdy),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] oh2i(input logic [NR-1:0] oh);
    oh2i = 4'hF;
    for (int i = 0; i < NR; i++) if (oh[i]) oh2i = 4'(i);
  endfunction

  // Record every handshake as {owner index, byte}.
  always @(negedge clk) if (!rst && tx_vld && tx_rdy) obs_q.push_back({oh2i(grant), tx_data});

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_pkt(input int r, input logic [7:0] b0, input logic [7:0] b1);
    logic acc;
    int n;
    for (int k = 0; k < 2; k++) begin
      req_vld[r] = 1'b1;
      req_data[8*r +: 8] = (k == 0) ? b0 : b1;
      req_last[r] = (k == 1);
      acc = 1'b0;
      n = 0;
      while (!acc) begin
        @(negedge clk);
        acc = req_rdy[r];
        @(posedge clk); #1;
        n++;
        if (!acc && n > 200) begin
          checks++; errors++;
          $display("FAIL send_req%0d: no req_rdy after %0d cycles, required within 200", r, n);
          acc = 1'b1;
        end
      end
    end
    req_vld[r] = 1'b0;
    req_last[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_vld = '0; req_data = '0; req_last = '0; tx_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({grant, req_rdy, tx_vld, tx_data, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b rdy=%b vld=%b data=%h busy=%b to=%b, required all 0",
               grant, req_rdy, tx_vld, tx_data, busy, timeout_err);
    end
    checks++;
    if (dut.rr_ptr_q !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr: %0d, required 0", dut.rr_ptr_q); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req_vld[1] = 1'b1; req_data[15:8] = 8'h12; req_last[1] = 1'b0;
    exp_q.push_back({4'd1, 8'h12});
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_pre: %b, required 0000", grant); end
    @(negedge clk);
    checks++;
    if ({grant, req_rdy, tx_vld, tx_data} !== {4'b0010, 4'b0010, 1'b1, 8'h12}) begin
      errors++;
      $display("FAIL single_grant: grant=%b rdy=%b vld=%b data=%h, required 0010 0010 1 12", grant, req_rdy, tx_vld, tx_data);
    end
    @(posedge clk); #1;
    req_data[15:8] = 8'h34; req_last[1] = 1'b1;
    exp_q.push_back({4'd1, 8'h34});
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h34 || tx_vld !== 1'b1) begin errors++; $display("FAIL single_byte2: vld=%b data=%h, required 1 34", tx_vld, tx_data); end
    @(posedge clk); #1;
    req_vld[1] = 1'b0; req_last[1] = 1'b0;
    for (int k = 0; k < GAP; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || grant !== 4'b0 || tx_vld !== 1'b0 || tx_data !== 8'h00) begin
        errors++;
        $display("FAIL single_gap%0d: busy=%b grant=%b vld=%b data=%h, required 1 0000 0 00", k, busy, grant, tx_vld, tx_data);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b, required 0", busy); end
    checks++;
    if (dut.rr_ptr_q !== 2'd2) begin errors++; $display("FAIL single_rr_ptr: %0d, required 2", dut.rr_ptr_q); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
      checks++; if (o !== e) begin errors++; $display("FAIL single_sb: got %h, required %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL single_extra: %0d extra transfers, required 0", obs_q.size()); end
    obs_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.push_back({4'd0, 8'h10}); exp_q.push_back({4'd0, 8'h11});
    exp_q.push_back({4'd2, 8'h30}); exp_q.push_back({4'd2, 8'h31});
    exp_q.push_back({4'd3, 8'h40}); exp_q.push_back({4'd3, 8'h41});
    fork
      send_pkt(0, 8'h10, 8'h11);
      send_pkt(2, 8'h30, 8'h31);
      send_pkt(3, 8'h40, 8'h41);
    join
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
      checks++; if (o !== e) begin errors++; $display("FAIL contention_sb: got %h, required %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL contention_extra: %0d extra transfers, required 0", obs_q.size()); end
    obs_q.delete();
    repeat (GAP + 2) @(posedge clk); #1;
  endtask

  task automatic test_lock();
    int n;
    int bad;
    req_vld[1] = 1'b1; req_data[15:8] = 8'h21; req_last[1] = 1'b0;
    exp_q.push_back({4'd1, 8'h21});
    @(posedge clk); @(posedge clk); #1;
    req_vld[1] = 1'b0;
    req_vld[0] = 1'b1; req_data[7:0] = 8'h0A; req_last[0] = 1'b1;
    exp_q.push_back({4'd1, 8'h22}); exp_q.push_back({4'd0, 8'h0A});
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (grant !== 4'b0010 || req_rdy[0] !== 1'b0 || tx_vld !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL lock_hold: %0d cycles lost the lock, required 0", bad); end
    @(posedge clk); #1;
    req_vld[1] = 1'b1; req_data[15:8] = 8'h22; req_last[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_rdy[1] && n < 50) begin @(negedge clk); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL lock_resume: req_rdy[1] absent %0d cycles, required prompt", n); end
    @(posedge clk); #1 req_vld[1] = 1'b0; req_last[1] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!req_rdy[0] && n < 50) begin @(negedge clk); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL lock_next: req_rdy[0] absent %0d cycles, required within gap", n); end
    @(posedge clk); #1 req_vld[0] = 1'b0; req_last[0] = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
      checks++; if (o !== e) begin errors++; $display("FAIL lock_sb: got %h, required %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL lock_extra: %0d extra transfers, required 0", obs_q.size()); end
    obs_q.delete();
    repeat (GAP + 2) @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int bad;
    tx_rdy = 1'b0;
    req_vld[2] = 1'b1; req_data[23:16] = 8'hAA; req_last[2] = 1'b1;
    exp_q.push_back({4'd2, 8'hAA});
    @(posedge clk);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (tx_vld !== 1'b1 || tx_data !== 8'hAA || req_rdy[2] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles, required 0", bad); end
    @(posedge clk); #1 tx_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (req_rdy !== 4'b0100) begin errors++; $display("FAIL bp_release: req_rdy=%b, required 0100", req_rdy); end
    @(posedge clk); #1 req_vld[2] = 1'b0; req_last[2] = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
      checks++; if (o !== e) begin errors++; $display("FAIL bp_sb: got %h, required %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bp_extra: %0d extra transfers, required 0", obs_q.size()); end
    obs_q.delete();
    repeat (GAP + 2) @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int pulses, to_k, n;
    logic [NR-1:0] g16, g17, g21, g22;
    req_vld[3] = 1'b1; req_data[31:24] = 8'h55; req_last[3] = 1'b0;
    req_vld[0] = 1'b1; req_data[7:0]   = 8'h0B; req_last[0] = 1'b1;
    exp_q.push_back({4'd3, 8'h55}); exp_q.push_back({4'd0, 8'h0B});
    @(posedge clk); @(posedge clk); #1;
    req_vld[3] = 1'b0;
    pulses = 0; to_k = -1; g16 = 'x; g17 = 'x; g21 = 'x; g22 = 'x;
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      if (timeout_err) begin pulses++; to_k = k; end
      if (k == 16) g16 = grant;
      if (k == 17) g17 = grant;
      if (k == 21) g21 = grant;
      if (k == 22) g22 = grant;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL to_pulses: %0d, required 1", pulses); end
    checks++; if (to_k != TO + 1) begin errors++; $display("FAIL to_time: cycle %0d, required %0d", to_k, TO + 1); end
    checks++; if (g16 !== 4'b1000) begin errors++; $display("FAIL to_held: grant=%b, required 1000", g16); end
    checks++; if (g17 !== 4'b0000) begin errors++; $display("FAIL to_clear: grant=%b, required 0000", g17); end
    checks++; if (g21 !== 4'b0000) begin errors++; $display("FAIL to_gap: grant=%b, required 0000", g21); end
    checks++; if (g22 !== 4'b0001) begin errors++; $display("FAIL to_next: grant=%b, required 0001", g22); end
    n = 0;
    while (!req_rdy[0] && n < 50) begin @(negedge clk); n++; end
    checks++; if (n >= 50) begin errors++; $display("FAIL to_xfer: req_rdy[0] absent %0d cycles", n); end
    @(posedge clk); #1 req_vld[0] = 1'b0; req_last[0] = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
      checks++; if (o !== e) begin errors++; $display("FAIL to_sb: got %h, required %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL to_extra: %0d extra transfers, required 0", obs_q.size()); end
    obs_q.delete();
    repeat (GAP + 2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    req_vld[1] = 1'b1; req_data[15:8] = 8'hFF; req_last[1] = 1'b0;
    exp_q.push_back({4'd1, 8'hFF});
    @(posedge clk); @(posedge clk); #1;
    req_data[15:8] = 8'h00; req_last[1] = 1'b1; tx_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0010 || tx_vld !== 1'b1) begin errors++; $display("FAIL rmid_pre: grant=%b vld=%b, required 0010 1", grant, tx_vld); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({grant, req_rdy, tx_vld, tx_data, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL rmid_async: grant=%b rdy=%b vld=%b data=%h busy=%b to=%b, required all 0",
               grant, req_rdy, tx_vld, tx_data, busy, timeout_err);
    end
    req_vld[1] = 1'b0; req_last[1] = 1'b0; tx_rdy = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
      checks++; if (o !== e) begin errors++; $display("FAIL rmid_sb1: got %h, required %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rmid_extra: %0d extra transfers, required 0", obs_q.size()); end
    obs_q.delete();
    exp_q.push_back({4'd0, 8'h01}); exp_q.push_back({4'd0, 8'h02});
    exp_q.push_back({4'd1, 8'h03}); exp_q.push_back({4'd1, 8'h04});
    fork
      send_pkt(0, 8'h01, 8'h02);
      send_pkt(1, 8'h03, 8'h04);
      begin
        @(negedge clk); @(negedge clk);
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("FAIL rmid_prio: grant=%b, required 0001", grant); end
      end
    join
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
      checks++; if (o !== e) begin errors++; $display("FAIL rmid_sb2: got %h, required %h", o, e); end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rmid_extra2: %0d extra transfers, required 0", obs_q.size()); end
    obs_q.delete();
    repeat (GAP + 2) @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte-stream requesters, e.g. a command responder, a status reporter and a debug port. It grants the transmitter for a whole packet, delimited by `req_last`, so bytes from different requesters never interleave. It inserts a programmable idle gap between packets and aborts a packet whose owner stalls too long. It sits between the requesters and `uart_tx`, whose byte interface is valid/ready: `tx_vld`, `tx_data`, `tx_rdy`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 868: idle clk cycles inserted after every packet; 868 is one bit time at 100 MHz / 115200 baud. 0 means no gap.
- `TIMEOUT_CYCLES`, 65535: consecutive clk cycles with the owner's `req_vld` low before the packet is aborted. 0 disables the timeout.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous, active-high.
- `req_vld` in NUM_REQ: per-requester byte valid.
- `req_data` in 8*NUM_REQ: requester i's byte is `[8i+7:8i]`.
- `req_last` in NUM_REQ: qualifies the byte as the last of its packet.
- `req_rdy` out NUM_REQ: per-requester byte accepted.
- `tx_vld` out 1: byte valid to `uart_tx`.
- `tx_data` out 8: byte to `uart_tx`.
- `tx_rdy` in 1: `uart_tx` accepts the byte.
- `grant` out NUM_REQ: one-hot current owner; all zero when not in GRANT.
- `busy` out 1: high in GRANT or GAP.
- `timeout_err` out 1: one-cycle pulse when a packet is aborted.

## Operation
- States: IDLE, GRANT, GAP. The state, `grant`, `rr_ptr` (width `$clog2(NUM_REQ)`), the gap counter and the timeout counter are all registers.
- IDLE, when any `req_vld` is high:
  - Select the first set index scanning `rr_ptr`, `rr_ptr+1`, … with wrap modulo NUM_REQ.
  - Register the one-hot `grant` and go to GRANT.
  - `req_last` is ignored in IDLE.
- GRANT, with g as the owner:
  - `tx_vld` = `req_vld[g]`.
  - `tx_data` = `req_data[g]`.
  - `req_rdy[g]` = `tx_rdy`; all other `req_rdy` bits are 0.
  - These paths are combinational from the registered `grant`.
- Transfer: `tx_vld && tx_rdy` in GRANT.
- Transfer with `req_last[g]`:
  - `rr_ptr` <= (g+1) mod NUM_REQ.
  - Clear `grant`.
  - Go to GAP, or to IDLE if `GAP_CYCLES` == 0.
- Lock: while in GRANT, requests from other requesters are ignored even if the owner's `req_vld` is low.
- Timeout, when `TIMEOUT_CYCLES` != 0:
  - The counter clears on every cycle the owner's `req_vld` is high, and on entry to GRANT.
  - Otherwise it increments, saturating.
  - When it reaches `TIMEOUT_CYCLES`, the next edge pulses `timeout_err`, advances `rr_ptr` past g, clears `grant` and goes to GAP (or IDLE).
  - An abort only occurs while `tx_vld` is low, so the transmitter handshake is never violated.
- GAP:
  - The counter loads 0 on entry and increments each cycle.
  - Exit to IDLE on the edge where the count equals `GAP_CYCLES`-1, so the arbiter is in GAP for exactly `GAP_CYCLES` cycles.
  - `req_rdy`, `tx_vld` and `grant` are all 0.
- Requesters must hold `req_vld`, `req_data` and `req_last` stable until `req_rdy`. The arbiter does not buffer data.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, counters 0. Outputs `grant` 0, `req_rdy` 0, `tx_vld` 0, `tx_data` 0, `busy` 0, `timeout_err` 0.
- Reset asserted mid-packet: all outputs are 0 immediately (asynchronous). The partial packet is lost, and after release arbitration restarts from requester 0.
- Grant latency: `req_vld` high in IDLE at edge N puts `grant` and `tx_vld` high after edge N. A byte can therefore transfer in the cycle after the request is first seen.
- Back-to-back bytes within a packet: one per cycle when `tx_rdy` allows. There is no bubble between bytes.
- Last-byte transfer at edge N:
  - `grant` and `tx_vld` are 0 after N.
  - With gap, the next `grant` appears after edge N+GAP_CYCLES+1.
  - With no gap, it appears after edge N+1.
- Simultaneous requests resolve by `rr_ptr` only. A requester that just finished has the lowest priority.
- `tx_data` is 0 whenever `tx_vld` is 0.

## Test plan
- Single requester, NUM_REQ=4, GAP_CYCLES=4: req1 sends 0x12, 0x34 (last). Required:
  - `grant`=0010 one cycle after `req_vld`.
  - Two transfers with `tx_data` 0x12 then 0x34.
  - `busy` stays high for 4 cycles after the last byte, then IDLE.
  - `rr_ptr`=2.
- Contention: req0, req2 and req3 all post 2-byte packets simultaneously from reset. Required:
  - Grant order 0, 2, 3.
  - No interleaving of bytes between packets.
  - Every byte appears exactly once on `tx_data`.
- Lock: req1 owns and drops `req_vld` for 10 cycles mid-packet while req0 is valid. Required:
  - `grant` stays 0010.
  - `req_rdy[0]`=0.
  - req1 resumes and completes its packet.
- Backpressure: `tx_rdy` is low for 50 cycles while req2 holds 0xAA valid. Required:
  - `tx_vld` and `tx_data` = 0xAA stay stable throughout.
  - `req_rdy[2]` stays 0 until `tx_rdy` rises.
  - Exactly one transfer occurs.
- Timeout, TIMEOUT_CYCLES=16: the owner sends 0x55 (not last), then stays silent. Required:
  - `timeout_err` is a single pulse 16 cycles later.
  - `grant` clears.
  - The next pending requester is granted after the gap.
- Reset mid-packet: assert `rst` during a 0xFF, 0x00 packet. Required:
  - Outputs are 0 asynchronously.
  - After release, req0 has priority on contention.
